// File: rtl/keypad_debounce_bank_pkg.sv
// Shared constants and helpers for the keypad debounce bank.
package keypad_debounce_bank_pkg;

  localparam int DEBOUNCE_SYNC_STAGES = 2;
  localparam int DEFAULT_DEPTH        = 4;
  localparam int DEFAULT_TICK_DIV     = 1;

  // Counter width for a divider: clog2 with a floor of one bit.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/keypad_debounce_bank_channel.sv
// One debounce channel: input synchroniser, sample history and stable-level
// decision with single-cycle rise/fall strobes.
module debounce_channel
  import keypad_debounce_bank_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic Clock,
  input  logic Reset,
  input  logic sample,
  input  logic Enable,
  input  logic Load,
  input  logic R,
  input  logic In,
  output logic Q,
  output logic Rise,
  output logic Fall,
  output logic q_next
);

  logic [DEBOUNCE_SYNC_STAGES-1:0] sync_reg;
  logic [DEPTH-1:0]                hist_reg, hist_next;
  logic                            q_reg, rise_reg, fall_reg;
  logic                            rise_next, fall_next;
  logic                            s2;

  assign s2 = sync_reg[DEBOUNCE_SYNC_STAGES-1];

  // The decision looks at the history as it stands before this cycle's shift.
  always_comb begin
    hist_next = hist_reg;
    q_next    = q_reg;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (Load) begin
      hist_next = {DEPTH{R}};
      q_next    = R;
    end else if (Enable) begin
      if (sample)
        hist_next = {hist_reg[DEPTH-2:0], s2};
      if ((&hist_reg) && !q_reg) begin
        q_next    = 1'b1;
        rise_next = 1'b1;
      end else if (!(|hist_reg) && q_reg) begin
        q_next    = 1'b0;
        fall_next = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_reg <= '0;
      hist_reg <= '0;
      q_reg    <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[DEBOUNCE_SYNC_STAGES-2:0], In};
      hist_reg <= hist_next;
      q_reg    <= q_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
    end
  end

  assign Q    = q_reg;
  assign Rise = rise_reg;
  assign Fall = fall_reg;

endmodule

// File: rtl/keypad_debounce_bank.sv
// Multi-channel keypad debouncer: shared sample prescaler, Tick/Any
// registers and one debounce_channel per input line.
module keypad_debounce_bank
  import keypad_debounce_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                Load,
  input  logic [CHANNELS-1:0] R,
  input  logic [CHANNELS-1:0] In,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] Rise,
  output logic [CHANNELS-1:0] Fall,
  output logic                Any,
  output logic                Tick
);

  localparam int             CW       = cnt_width(TICK_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                sample;
  logic                tick_reg, any_reg;
  logic [CHANNELS-1:0] q_next;

  // A Load cycle swallows any sample that would have landed on it.
  assign sample = Enable && !Load && (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (Load)
      cnt_next = '0;
    else if (Enable)
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
      any_reg  <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      tick_reg <= sample;
      any_reg  <= |q_next;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      debounce_channel #(.DEPTH(DEPTH)) u_ch (
        .Clock  (Clock),
        .Reset  (Reset),
        .sample (sample),
        .Enable (Enable),
        .Load   (Load),
        .R      (R[gi]),
        .In     (In[gi]),
        .Q      (Q[gi]),
        .Rise   (Rise[gi]),
        .Fall   (Fall[gi]),
        .q_next (q_next[gi])
      );
    end
  endgenerate

  assign Tick = tick_reg;
  assign Any  = any_reg;

endmodule
